// File: rtl/reg_cmd_pkg.sv
// reg_cmd_pkg: opcodes, FSM state encoding and read-wait limit shared by the command front-end
package reg_cmd_pkg;

    localparam logic [7:0] OP_WR = 8'hAA;
    localparam logic [7:0] OP_RD = 8'hBB;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_ADDR = 3'd1;
    localparam logic [2:0] S_WR_DATA = 3'd2;
    localparam logic [2:0] S_RD_ADDR = 3'd3;
    localparam logic [2:0] S_RD_WAIT = 3'd4;
    localparam logic [2:0] S_TX_SEND = 3'd5;

    typedef enum logic [2:0] {
        IDLE    = S_IDLE,
        WR_ADDR = S_WR_ADDR,
        WR_DATA = S_WR_DATA,
        RD_ADDR = S_RD_ADDR,
        RD_WAIT = S_RD_WAIT,
        TX_SEND = S_TX_SEND
    } state_t;

    localparam int RD_WAIT_MAX = 4;
    localparam int RD_WAIT_W   = $clog2(RD_WAIT_MAX);

endpackage

// File: rtl/reg_cmd_timer.sv
// reg_cmd_timer: clearable up-counter that saturates at MAX-1 and flags it on tc
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear to 0 (wins over counting)
//   tc       : counter has reached MAX-1
module reg_cmd_timer #(
    parameter int MAX = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tc
);

    localparam int W = (MAX > 1) ? $clog2(MAX) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    assign tc = cnt_q == W'(MAX - 1);

    always_comb cnt_d = clr ? '0 : tc ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;

endmodule

// File: rtl/reg_cmd_ctrl.sv
// reg_cmd_ctrl: parses UART byte frames into register-file write/read strobes and returns read data over TX
//   CLK, RST              : clock, asynchronous active-high reset
//   RX_Data, RX_Vld       : received byte and its one-cycle strobe
//   WrEn, RdEn            : one-cycle register-file write / read strobes
//   Address, WrData       : register-file address (held between commands) and write data
//   RdData, RdData_VLD    : register-file read data and its valid
//   TX_Data, TX_Vld       : byte to transmit, pending until accepted while TX_Busy is low
//   TX_Busy               : transmitter cannot accept a byte
//   Cmd_Err               : one-cycle frame-error pulse
//   Optional REG_CMD_TIMEOUT_EN: abandon a partial frame after TIMEOUT_CYC-1 idle cycles
module reg_cmd_ctrl
    import reg_cmd_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 16,
    parameter int ADDR        = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] RX_Data,
    input  logic             RX_Vld,
    output logic             WrEn,
    output logic             RdEn,
    output logic [ADDR-1:0]  Address,
    output logic [WIDTH-1:0] WrData,
    input  logic [WIDTH-1:0] RdData,
    input  logic             RdData_VLD,
    output logic [WIDTH-1:0] TX_Data,
    output logic             TX_Vld,
    input  logic             TX_Busy,
    output logic             Cmd_Err
);

    state_t                 state_q, state_d;
    logic [ADDR-1:0]        addr_q, addr_d;
    logic [WIDTH-1:0]       wr_data_q, wr_data_d;
    logic [WIDTH-1:0]       tx_data_q, tx_data_d;
    logic                   wr_en_q, wr_en_d;
    logic                   rd_en_q, rd_en_d;
    logic                   tx_vld_q, tx_vld_d;
    logic                   err_q, err_d;
    logic [RD_WAIT_W-1:0]   wait_q, wait_d;
    logic                   is_wr, is_rd, bad_addr, tmo;

    assign is_wr    = RX_Data == WIDTH'(OP_WR);
    assign is_rd    = RX_Data == WIDTH'(OP_RD);
    assign bad_addr = {1'b0, RX_Data} >= (WIDTH + 1)'(DEPTH);

`ifdef REG_CMD_TIMEOUT_EN
    logic in_frame;

    assign in_frame = state_q inside {WR_ADDR, WR_DATA, RD_ADDR};

    // Idle time is only measured inside a partial frame; any received byte restarts it.
    reg_cmd_timer #(.MAX(TIMEOUT_CYC)) u_timer (
        .clk (CLK),
        .rst (RST),
        .clr (!in_frame || RX_Vld),
        .tc  (tmo)
    );
`else
    assign tmo = 1'b0 && (TIMEOUT_CYC > 0);
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        tx_data_d = tx_data_q;
        tx_vld_d  = tx_vld_q;
        wait_d    = wait_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: if (RX_Vld) begin
                state_d = is_wr ? WR_ADDR : is_rd ? RD_ADDR : IDLE;
                err_d   = !is_wr && !is_rd;
            end
            WR_ADDR, RD_ADDR: if (RX_Vld) begin
                if (bad_addr) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    addr_d  = RX_Data[ADDR-1:0];
                    state_d = (state_q == WR_ADDR) ? WR_DATA : RD_WAIT;
                    rd_en_d = state_q == RD_ADDR;
                    wait_d  = '0;
                end
            end else if (tmo) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end
            WR_DATA: if (RX_Vld) begin
                wr_data_d = RX_Data;
                wr_en_d   = 1'b1;
                state_d   = IDLE;
            end else if (tmo) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end
            RD_WAIT: begin
                err_d = RX_Vld;
                // wait_q counts cycles since RdEn; the last allowed cycle still accepts data
                if (RdData_VLD) begin
                    tx_data_d = RdData;
                    tx_vld_d  = 1'b1;
                    state_d   = TX_SEND;
                end else if (wait_q == RD_WAIT_W'(RD_WAIT_MAX - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            TX_SEND: begin
                err_d = RX_Vld;
                if (!TX_Busy) begin
                    tx_vld_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wr_data_q <= '0;
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
            wait_q    <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            tx_data_q <= tx_data_d;
            tx_vld_q  <= tx_vld_d;
            wait_q    <= wait_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            err_q     <= err_d;
        end

    assign WrEn    = wr_en_q;
    assign RdEn    = rd_en_q;
    assign Address = addr_q;
    assign WrData  = wr_data_q;
    assign TX_Data = tx_data_q;
    assign TX_Vld  = tx_vld_q;
    assign Cmd_Err = err_q;

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// tb_reg_cmd_ctrl: scoreboard bench for reg_cmd_ctrl (write/read frames, errors, reset, timeout)
module tb_reg_cmd_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] RX_Data = 8'h00;
    logic       RX_Vld = 1'b0;
    logic       WrEn, RdEn, RdData_VLD, TX_Vld, Cmd_Err;
    logic [3:0] Address;
    logic [7:0] WrData, RdData, TX_Data;
    logic       TX_Busy = 1'b0;
    bit         no_resp = 1'b0;
    int         n_run = 0;
    int         n_fail = 0;
    logic [15:0] sb[$];

    always #5 CLK = ~CLK;

    reg_cmd_ctrl #(.WIDTH(8), .DEPTH(16), .ADDR(4), .TIMEOUT_CYC(16)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_Data    (RX_Data),
        .RX_Vld     (RX_Vld),
        .WrEn       (WrEn),
        .RdEn       (RdEn),
        .Address    (Address),
        .WrData     (WrData),
        .RdData     (RdData),
        .RdData_VLD (RdData_VLD),
        .TX_Data    (TX_Data),
        .TX_Vld     (TX_Vld),
        .TX_Busy    (TX_Busy),
        .Cmd_Err    (Cmd_Err)
    );

    // register file: answers one cycle after RdEn with 0x1F + address
    always @(posedge CLK or posedge RST)
        if (RST) begin
            RdData_VLD <= 1'b0;
            RdData     <= 8'h00;
        end else begin
            RdData_VLD <= RdEn && !no_resp;
            RdData     <= 8'h1F + {4'h0, Address};
        end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_ev(input logic [15:0] ev);
        if (sb.size() == 0) chk("unexpected_evt", ev, 0);
        else                chk("evt", ev, sb.pop_front());
    endtask

    // events: 1=Cmd_Err, 2=write {addr,data}, 3=read {addr}, 4=TX transfer {data}
    always @(negedge CLK)
        if (!RST) begin
            if (WrEn || RdEn) chk("wr_rd_excl", WrEn && RdEn, 0);
            if (Cmd_Err) expect_ev({4'h1, 12'h000});
            if (WrEn) expect_ev({4'h2, Address, WrData});
            if (RdEn) expect_ev({4'h3, Address, 8'h00});
            if (TX_Vld && !TX_Busy) expect_ev({4'h4, 4'h0, TX_Data});
        end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        RX_Data = b;
        RX_Vld  = 1'b1;
        tick();
        RX_Vld  = 1'b0;
    endtask

    task automatic wait_tx();
        int i = 0;
        while (!TX_Vld && i < 10) begin
            tick();
            i++;
        end
        chk("tx_vld_rise", TX_Vld, 1);
    endtask

    task automatic chk_reset_outs();
        chk("rst_wren", WrEn, 0);
        chk("rst_rden", RdEn, 0);
        chk("rst_addr", Address, 0);
        chk("rst_wrdata", WrData, 0);
        chk("rst_txdata", TX_Data, 0);
        chk("rst_txvld", TX_Vld, 0);
        chk("rst_err", Cmd_Err, 0);
    endtask

    initial begin
        tick(2);
        chk_reset_outs();
        RST = 1'b0;
        tick();
        // plain write
        sb.push_back({4'h2, 4'h5, 8'h3C});
        send(8'hAA); send(8'h05); send(8'h3C);
        tick(3);
        // read with TX back-pressure
        TX_Busy = 1'b1;
        sb.push_back({4'h3, 4'h2, 8'h00});
        send(8'hBB); send(8'h02);
        wait_tx();
        repeat (10) begin
            chk("tx_hold_vld", TX_Vld, 1);
            chk("tx_hold_data", TX_Data, 8'h21);
            tick();
        end
        sb.push_back({4'h4, 4'h0, 8'h21});
        TX_Busy = 1'b0;
        tick();
        chk("tx_vld_drop", TX_Vld, 0);
        // bad opcode, then out-of-range address followed by a stray byte in IDLE
        sb.push_back({4'h1, 12'h000});
        send(8'h55);
        tick(2);
        sb.push_back({4'h1, 12'h000});
        sb.push_back({4'h1, 12'h000});
        send(8'hAA); send(8'h10); send(8'hFF);
        tick(3);
        // byte arriving while a TX byte is pending
        TX_Busy = 1'b1;
        sb.push_back({4'h3, 4'h7, 8'h00});
        send(8'hBB); send(8'h07);
        wait_tx();
        sb.push_back({4'h1, 12'h000});
        send(8'h77);
        tick(2);
        chk("tx_intact", TX_Data, 8'h26);
        sb.push_back({4'h4, 4'h0, 8'h26});
        TX_Busy = 1'b0;
        tick();
        chk("tx_vld_drop2", TX_Vld, 0);
        // register file never answers
        no_resp = 1'b1;
        sb.push_back({4'h3, 4'h4, 8'h00});
        sb.push_back({4'h1, 12'h000});
        send(8'hBB); send(8'h04);
        tick(8);
        no_resp = 1'b0;
        // reset mid-frame
        send(8'hAA); send(8'h03);
        RST = 1'b1;
        tick();
        chk_reset_outs();
        tick();
        RST = 1'b0;
        tick();
        sb.push_back({4'h2, 4'h3, 8'h9A});
        send(8'hAA); send(8'h03); send(8'h9A);
        tick(3);
        // back-to-back writes with no gap
        sb.push_back({4'h2, 4'hA, 8'h5A});
        sb.push_back({4'h2, 4'hB, 8'hA5});
        send(8'hAA); send(8'h0A); send(8'h5A);
        send(8'hAA); send(8'h0B); send(8'hA5);
        tick(3);
        // stalled partial frame
`ifdef REG_CMD_TIMEOUT_EN
        sb.push_back({4'h1, 12'h000});
        send(8'hAA);
        tick(20);
        sb.push_back({4'h2, 4'h1, 8'h11});
        send(8'hAA); send(8'h01); send(8'h11);
`else
        send(8'hAA);
        tick(20);
        sb.push_back({4'h2, 4'h1, 8'h11});
        send(8'h01); send(8'h11);
`endif
        tick(3);
        for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
        chk("sb_drained", sb.size(), 0);
        chk("addr_hold", Address, 1);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
